// File: rtl/frame_packer.sv
// frame_packer
//   Wraps a stream of payload words into frames for a downstream FIFO:
//     HEADER_WORD, FRAME_LEN payload words, XOR checksum of the payload.
//   Every word is written with a registered one-cycle insert strobe. The
//   downstream full flag stalls the frame in whichever state it is in.
//
// Ports
//   fast_clk      clock, rising edge
//   rst           synchronous, active-high reset
//   in_valid      upstream payload word valid
//   in_data       upstream payload word
//   out_ready     upstream ready (combinational); transfer = in_valid & out_ready
//   in_fifo_full  downstream FIFO full flag
//   out_insert    one-cycle FIFO insert strobe (registered)
//   out_data      word to the FIFO (registered, holds while out_insert=0)
//   out_busy      high whenever a frame is in progress
//   out_frames    completed frame count, wraps modulo 2^CNT_BITS
module frame_packer #(
  parameter int unsigned     BITS        = 8,
  parameter int unsigned     FRAME_LEN   = 4,
  parameter logic [BITS-1:0] HEADER_WORD = 8'hA5,
  parameter int unsigned     CNT_BITS    = 16
) (
  input  logic                fast_clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [BITS-1:0]     in_data,
  output logic                out_ready,
  input  logic                in_fifo_full,
  output logic                out_insert,
  output logic [BITS-1:0]     out_data,
  output logic                out_busy,
  output logic [CNT_BITS-1:0] out_frames
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HEADER   = 2'd1,
    PAYLOAD  = 2'd2,
    CHECKSUM = 2'd3
  } state_t;

  // FRAME_LEN is at most 255, so an 8-bit payload index always suffices.
  localparam logic [7:0]          LAST_IDX  = 8'(FRAME_LEN - 1);
  localparam logic [CNT_BITS-1:0] FRAME_INC = CNT_BITS'(1);

  state_t              state, state_nxt;
  logic [7:0]          count, count_nxt;
  logic [BITS-1:0]     csum, csum_nxt;
  logic                insert_nxt;
  logic [BITS-1:0]     data_nxt;
  logic [CNT_BITS-1:0] frames_nxt;
  logic                transfer;

  // Reset is folded into the combinational outputs so that upstream never
  // sees ready (and nobody sees busy) during a reset cycle, whatever state
  // the register happens to hold before the reset edge.
  assign out_ready = !rst && (state == PAYLOAD) && !in_fifo_full;
  assign out_busy  = !rst && (state != IDLE);
  assign transfer  = in_valid && out_ready;

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    insert_nxt = 1'b0;
    data_nxt   = out_data;
    count_nxt  = count;
    csum_nxt   = csum;
    frames_nxt = out_frames;

    case (state)
      IDLE: begin
        // The word that triggers the frame is left for PAYLOAD to consume.
        if (in_valid) begin
          state_nxt = HEADER;
        end
      end

      HEADER: begin
        if (!in_fifo_full) begin
          insert_nxt = 1'b1;
          data_nxt   = HEADER_WORD;
          count_nxt  = '0;
          csum_nxt   = '0;
          state_nxt  = PAYLOAD;
        end
      end

      PAYLOAD: begin
        if (transfer) begin
          insert_nxt = 1'b1;
          data_nxt   = in_data;
          csum_nxt   = csum ^ in_data;
          count_nxt  = count + 8'd1;
          if (count == LAST_IDX) begin
            state_nxt = CHECKSUM;
          end
        end
      end

      CHECKSUM: begin
        if (!in_fifo_full) begin
          insert_nxt = 1'b1;
          data_nxt   = csum;
          frames_nxt = out_frames + FRAME_INC;
          state_nxt  = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      out_insert <= 1'b0;
      out_data   <= '0;
      out_frames <= '0;
      count      <= '0;
      csum       <= '0;
    end else begin
      out_insert <= insert_nxt;
      out_data   <= data_nxt;
      out_frames <= frames_nxt;
      count      <= count_nxt;
      csum       <= csum_nxt;
    end
  end

endmodule

// File: tb/tb_frame_packer.sv
// tb_frame_packer
//   Directed bench for frame_packer. A vector table drives the default
//   instance (FRAME_LEN=4) through normal frames, stalls in each state and a
//   mid-frame reset; a second instance (FRAME_LEN=1, CNT_BITS=2) is run by a
//   hand-written loop covering the single-word frame and counter wrap.
module tb_frame_packer;

  logic        fast_clk;
  logic        rst;

  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_fifo_full;
  logic        out_ready;
  logic        out_insert;
  logic [7:0]  out_data;
  logic        out_busy;
  logic [15:0] out_frames;

  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_full;
  logic        s_ready;
  logic        s_insert;
  logic [7:0]  s_out;
  logic        s_busy;
  logic [1:0]  s_frames;

  frame_packer #(
    .BITS(8), .FRAME_LEN(4), .HEADER_WORD(8'hA5), .CNT_BITS(16)
  ) dut (
    .fast_clk(fast_clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .out_ready(out_ready),
    .in_fifo_full(in_fifo_full), .out_insert(out_insert), .out_data(out_data),
    .out_busy(out_busy), .out_frames(out_frames)
  );

  frame_packer #(
    .BITS(8), .FRAME_LEN(1), .HEADER_WORD(8'hA5), .CNT_BITS(2)
  ) dut_short (
    .fast_clk(fast_clk), .rst(rst),
    .in_valid(s_valid), .in_data(s_data), .out_ready(s_ready),
    .in_fifo_full(s_full), .out_insert(s_insert), .out_data(s_out),
    .out_busy(s_busy), .out_frames(s_frames)
  );

  initial fast_clk = 1'b0;
  always #5 fast_clk = ~fast_clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One row: inputs applied for one edge; ready/busy expected before the
  // edge, insert/data/frames expected just after it.
  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  d;
    logic        f;
    logic        r;
    logic        b;
    logic        i;
    logic [7:0]  od;
    logic [15:0] fr;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r_, input logic v, input logic [7:0] d, input logic f,
                     input logic r, input logic b, input logic i,
                     input logic [7:0] od, input logic [15:0] fr);
    vec_t e;
    e.rst = r_; e.v = v; e.d = d; e.f = f;
    e.r = r; e.b = b; e.i = i; e.od = od; e.fr = fr;
    tbl.push_back(e);
  endtask

  int unsigned frames_exp [5];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_fifo_full = 1'b0;
    s_valid = 1'b0; s_data = '0; s_full = 1'b0;

    //   rst v  data   full | rdy busy | ins data   frames
    // reset, including a valid word offered during reset
    add(1, 0, 8'h00, 0,  0, 0,  0, 8'h00, 0);
    add(1, 1, 8'h55, 0,  0, 0,  0, 8'h00, 0);
    // plain frame 01..04 -> A5 01 02 03 04 04
    add(0, 1, 8'h01, 0,  0, 0,  0, 8'h00, 0);
    add(0, 1, 8'h01, 0,  0, 1,  1, 8'hA5, 0);
    add(0, 1, 8'h01, 0,  1, 1,  1, 8'h01, 0);
    add(0, 1, 8'h02, 0,  1, 1,  1, 8'h02, 0);
    add(0, 1, 8'h03, 0,  1, 1,  1, 8'h03, 0);
    add(0, 1, 8'h04, 0,  1, 1,  1, 8'h04, 0);
    add(0, 1, 8'h05, 0,  0, 1,  1, 8'h04, 1);
    add(0, 0, 8'h00, 0,  0, 0,  0, 8'h04, 1);
    // full for 3 cycles in PAYLOAD, then a valid gap
    add(0, 1, 8'h01, 0,  0, 0,  0, 8'h04, 1);
    add(0, 1, 8'h01, 0,  0, 1,  1, 8'hA5, 1);
    add(0, 1, 8'h01, 0,  1, 1,  1, 8'h01, 1);
    add(0, 1, 8'h02, 1,  0, 1,  0, 8'h01, 1);
    add(0, 1, 8'h02, 1,  0, 1,  0, 8'h01, 1);
    add(0, 1, 8'h02, 1,  0, 1,  0, 8'h01, 1);
    add(0, 1, 8'h02, 0,  1, 1,  1, 8'h02, 1);
    add(0, 0, 8'h99, 0,  1, 1,  0, 8'h02, 1);
    add(0, 1, 8'h03, 0,  1, 1,  1, 8'h03, 1);
    add(0, 1, 8'h04, 0,  1, 1,  1, 8'h04, 1);
    add(0, 0, 8'h00, 0,  0, 1,  1, 8'h04, 2);
    // full held in HEADER and in CHECKSUM; checksum 10^20^30^40 = 40
    add(0, 1, 8'h10, 1,  0, 0,  0, 8'h04, 2);
    add(0, 1, 8'h10, 1,  0, 1,  0, 8'h04, 2);
    add(0, 1, 8'h10, 1,  0, 1,  0, 8'h04, 2);
    add(0, 1, 8'h10, 0,  0, 1,  1, 8'hA5, 2);
    add(0, 1, 8'h10, 0,  1, 1,  1, 8'h10, 2);
    add(0, 1, 8'h20, 0,  1, 1,  1, 8'h20, 2);
    add(0, 1, 8'h30, 0,  1, 1,  1, 8'h30, 2);
    add(0, 1, 8'h40, 0,  1, 1,  1, 8'h40, 2);
    add(0, 0, 8'h00, 1,  0, 1,  0, 8'h40, 2);
    add(0, 0, 8'h00, 1,  0, 1,  0, 8'h40, 2);
    add(0, 0, 8'h00, 0,  0, 1,  1, 8'h40, 3);
    // reset after payload 10, 20 with a simultaneous transfer offered
    add(0, 1, 8'h10, 0,  0, 0,  0, 8'h40, 3);
    add(0, 1, 8'h10, 0,  0, 1,  1, 8'hA5, 3);
    add(0, 1, 8'h10, 0,  1, 1,  1, 8'h10, 3);
    add(0, 1, 8'h20, 0,  1, 1,  1, 8'h20, 3);
    add(1, 1, 8'h30, 0,  0, 0,  0, 8'h00, 0);
    add(0, 0, 8'h00, 0,  0, 0,  0, 8'h00, 0);
    add(0, 1, 8'h01, 0,  0, 0,  0, 8'h00, 0);
    add(0, 1, 8'h01, 0,  0, 1,  1, 8'hA5, 0);
    add(0, 1, 8'h01, 0,  1, 1,  1, 8'h01, 0);
    add(0, 1, 8'h02, 0,  1, 1,  1, 8'h02, 0);
    add(0, 1, 8'h03, 0,  1, 1,  1, 8'h03, 0);
    add(0, 1, 8'h04, 0,  1, 1,  1, 8'h04, 0);
    add(0, 0, 8'h00, 0,  0, 1,  1, 8'h04, 1);
    add(0, 0, 8'h00, 0,  0, 0,  0, 8'h04, 1);

    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge fast_clk);
      rst = tbl[k].rst; in_valid = tbl[k].v; in_data = tbl[k].d; in_fifo_full = tbl[k].f;
      #1;
      check($sformatf("row%0d ready", k), 32'(out_ready), 32'(tbl[k].r));
      check($sformatf("row%0d busy", k),  32'(out_busy),  32'(tbl[k].b));
      @(posedge fast_clk);
      #1;
      check($sformatf("row%0d insert", k), 32'(out_insert), 32'(tbl[k].i));
      check($sformatf("row%0d data", k),   32'(out_data),   32'(tbl[k].od));
      check($sformatf("row%0d frames", k), 32'(out_frames), 32'(tbl[k].fr));
    end

    // Single-word frames, continuous valid: IDLE, HEADER, PAYLOAD, CHECKSUM
    // per frame; 2-bit counter runs 1,2,3,0,1.
    frames_exp = '{1, 2, 3, 0, 1};
    @(negedge fast_clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int f = 0; f < 5; f++) begin
      for (int e = 0; e < 4; e++) begin
        @(negedge fast_clk);
        s_valid = 1'b1; s_data = 8'(8'h31 + f); s_full = 1'b0;
        #1;
        if (e == 2) check($sformatf("short f%0d ready_payload", f), 32'(s_ready), 32'd1);
        if (e == 3) check($sformatf("short f%0d ready_checksum", f), 32'(s_ready), 32'd0);
        @(posedge fast_clk);
        #1;
        if (e == 0) check($sformatf("short f%0d idle_insert", f), 32'(s_insert), 32'd0);
        if (e == 1) check($sformatf("short f%0d header", f), {23'd0, s_insert, s_out}, {23'd0, 1'b1, 8'hA5});
        if (e >= 2) check($sformatf("short f%0d word%0d", f, e), {23'd0, s_insert, s_out},
                          {23'd0, 1'b1, 8'(8'h31 + f)});
      end
      check($sformatf("short f%0d frames", f), 32'(s_frames), frames_exp[f]);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/frame_packer.md
FRAME_PACKER -- requirements
Module: frame_packer

Interface
REQ-001 Parameter BITS, default 8, width of input and output data words.
REQ-002 Parameter FRAME_LEN, default 4, payload words per frame (legal range 1 to 255).
REQ-003 Parameter HEADER_WORD, default 8'hA5, constant first word of every frame.
REQ-004 Parameter CNT_BITS, default 16, width of the frame counter.
REQ-005 fast_clk  in  1  clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 in_valid  in  1  upstream payload word valid.
REQ-008 in_data  in  BITS  upstream payload word.
REQ-009 out_ready  out  1  upstream ready; a word transfers on an edge where in_valid=1 and out_ready=1.
REQ-010 in_fifo_full  in  1  full flag of the downstream FIFO insert side.
REQ-011 out_insert  out  1  registered one-cycle strobe; FIFO insert of out_data.
REQ-012 out_data  out  BITS  registered word to the FIFO.
REQ-013 out_busy  out  1  high whenever state is not IDLE.
REQ-014 out_frames  out  CNT_BITS  count of completed frames.

Function
REQ-015 The state machine SHALL have four states: IDLE, HEADER, PAYLOAD, CHECKSUM.
REQ-016 IDLE: out_insert<=0; on in_valid=1 go to HEADER without consuming the word.
REQ-017 HEADER, in_fifo_full=0: out_insert<=1, out_data<=HEADER_WORD, payload count<=0, checksum<=0, go to PAYLOAD.
REQ-018 HEADER, in_fifo_full=1: out_insert<=0; stay in HEADER.
REQ-019 out_ready SHALL be combinational: 1 only in PAYLOAD with in_fifo_full=0; 0 in all other states.
REQ-020 PAYLOAD with a transfer: out_insert<=1, out_data<=in_data, checksum<=checksum XOR in_data, count<=count+1.
REQ-021 On the transfer where count=FRAME_LEN-1, the next state SHALL be CHECKSUM.
REQ-022 PAYLOAD without a transfer (in_valid=0 or full): out_insert<=0; count and checksum hold.
REQ-023 CHECKSUM, in_fifo_full=0: out_insert<=1, out_data<=final checksum, out_frames<=out_frames+1, go to IDLE.
REQ-024 CHECKSUM, in_fifo_full=1: out_insert<=0; stay in CHECKSUM.
REQ-025 out_frames SHALL wrap modulo 2^CNT_BITS (all-ones+1 -> 0).
REQ-026 Latency: a word accepted at edge N SHALL appear as out_data with out_insert=1 during the cycle after edge N.
REQ-027 out_data SHALL hold its last value when out_insert=0.
REQ-028 out_insert SHALL never be 1 for an edge at which in_fifo_full was 1.
REQ-029 Minimum frame is FRAME_LEN+2 out_insert strobes; back-to-back frames SHALL have one IDLE cycle between them.
REQ-030 With FRAME_LEN=1, PAYLOAD SHALL accept exactly one word, then go to CHECKSUM.

Reset
REQ-031 With rst=1 at an edge: state<=IDLE, out_insert<=0, out_data<=0, out_frames<=0, count<=0, checksum<=0.
REQ-032 rst SHALL take priority over every other input, including a simultaneous transfer.
REQ-033 A reset mid-frame SHALL discard the partial frame; no checksum word is emitted for it.
REQ-034 While rst=1, out_ready=0 and out_busy=0.

Verification
REQ-035 BITS=8, FRAME_LEN=4, in_fifo_full=0, in_valid=1, data 01,02,03,04 -> inserts A5,01,02,03,04,04; out_frames=1.
REQ-036 Same stream, in_fifo_full=1 for 3 cycles during PAYLOAD -> out_ready=0 for those 3 cycles; no inserts; output sequence unchanged.
REQ-037 in_fifo_full=1 while in HEADER and in CHECKSUM -> the state holds; A5 and the checksum are emitted once, on the first cycle after full drops.
REQ-038 rst=1 after payload words 10 and 20 -> no further inserts; out_frames=0; next frame 01..04 produces A5,01,02,03,04,04.
REQ-039 CNT_BITS=2, 5 consecutive frames -> out_frames sequence 1,2,3,0,1.
REQ-040 System check: feed the block into fifo with remove side clocked by clkgen at 10 MHz from 40 MHz -> slow side reads the exact frame word order with no drops or duplicates.
